pad_reader: RTL and testbench
=============================

PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 SHALL have parameter PAD_CLK_DIV, default 6: clk cycles per pad_clk half-period (legal range 2..255).
REQ-002 SHALL have parameter POLL_INTERVAL, default 16'd40000: clk cycles from one poll's start to the next (legal range ≥ 2*PAD_CLK_DIV*14).
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pad_latch, output, 1 bit: latch strobe to both gamepads.
REQ-006 SHALL have port pad_clk, output, 1 bit: shift clock to both gamepads; idles high.
REQ-007 SHALL have port pad_data, input, 2 bits: serial data, [0]=P1 and [1]=P2; active-low (0 = pressed).
REQ-008 SHALL have port p1_btn, output, 12 bits: P1 button state, active-high; bit i = i-th shifted bit.
REQ-009 SHALL have port p2_btn, output, 12 bits: P2 button state, same ordering as p1_btn.
REQ-010 SHALL have port btn_valid, output, 1 bit: one-cycle pulse in the cycle p1_btn/p2_btn update.

Function
REQ-011 SHALL implement FSM states WAIT, LATCH, SHIFT_LO, SHIFT_HI, DONE.
REQ-012 WAIT: poll counter counts to POLL_INTERVAL-1, then enters LATCH; counter restarts at LATCH entry, so the poll period is exactly POLL_INTERVAL cycles.
REQ-013 LATCH: pad_latch=1 for exactly 2*PAD_CLK_DIV cycles, pad_clk=1; then enters SHIFT_LO with bit index 0.
REQ-014 SHIFT_LO: pad_clk=0 for PAD_CLK_DIV cycles; in the last cycle, ~pad_data[0] and ~pad_data[1] are captured into bit [index] of the shadow registers.
REQ-015 SHIFT_HI: pad_clk=1 for PAD_CLK_DIV cycles; if index==11, enters DONE, else increments index and returns to SHIFT_LO.
REQ-016 DONE: lasts one cycle; copies the shadow registers to p1_btn/p2_btn (subject to REQ-024), asserts btn_valid, then returns to WAIT.
REQ-017 From LATCH entry to DONE SHALL be exactly 2*PAD_CLK_DIV + 24*PAD_CLK_DIV cycles.
REQ-018 p1_btn/p2_btn SHALL change only in DONE; partial shifts are never visible.
REQ-019 pad_latch and pad_clk SHALL be driven directly from registers (glitch-free).
REQ-020 Bit index and divider counters SHALL wrap/reset only on state entry; no overflow is possible within legal parameter ranges.

Reset
REQ-021 On reset_n=0, the block SHALL asynchronously enter WAIT with poll counter=0, pad_latch=0, pad_clk=1, p1_btn=0, p2_btn=0, btn_valid=0, shadow registers=0.
REQ-022 Reset asserted mid-poll SHALL abort the transfer with no btn_valid pulse; after release, the first poll starts POLL_INTERVAL cycles later.
REQ-023 Reset release SHALL take effect on the first clk rising edge after reset_n goes high.

Configuration
REQ-024 With PAD_READER_DEBOUNCE_EN defined, a new per-player value SHALL reach p1_btn/p2_btn only if two consecutive polls captured identical shadow values; otherwise that output holds. btn_valid still pulses every DONE.
REQ-025 Without PAD_READER_DEBOUNCE_EN, every DONE SHALL load the shadow values directly, and no compare register SHALL be synthesized.

Verification
REQ-026 PAD_CLK_DIV=2, POLL_INTERVAL=100; release reset -> pad_latch rises at cycle 100, stays high 4 cycles, then 12 pad_clk low/high pairs of 2 cycles each; btn_valid at cycle 153.
REQ-027 Mock pad P1 returning 12'hA5C (active-low on wire), P2 tied 0 -> p1_btn=12'h5A3, p2_btn=12'hFFF on btn_valid.
REQ-028 Assert reset_n low during the bit-5 SHIFT_LO -> pad_clk=1, pad_latch=0, outputs 0 immediately; no btn_valid until a full poll completes after release.
REQ-029 With PAD_READER_DEBOUNCE_EN: P1 reads 12'h001, then 12'h003, then 12'h003 on successive polls -> p1_btn stays 0 after polls 1-2 and becomes 12'h003 after poll 3.
REQ-030 Without PAD_READER_DEBOUNCE_EN, same stimulus -> p1_btn = 12'h001 after poll 1 and 12'h003 after poll 2.
REQ-031 Over 3 polls, btn_valid pulses exactly once per poll, and consecutive pulses are exactly POLL_INTERVAL cycles apart.

Source files
------------

// File: rtl/pad_reader.sv
// -----------------------------------------------------------------------------
// pad_reader
//   Polls two serial gamepads (shift-register style, 12 buttons each) at a
//   fixed interval. Each poll issues a latch strobe, then shifts in 12 bits
//   on pad_clk. The result is published on p1_btn/p2_btn together with a
//   one-cycle btn_valid pulse.
//
// Parameters
//   PAD_CLK_DIV   : clk cycles per pad_clk half-period (2..255)
//   POLL_INTERVAL : clk cycles between the starts of consecutive polls
//
// Ports
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   pad_latch  out  latch strobe to both pads (registered)
//   pad_clk    out  shift clock to both pads, idles high (registered)
//   pad_data   in   [0]=P1, [1]=P2 serial data, active-low
//   p1_btn     out  P1 buttons, active-high, bit i = i-th shifted bit
//   p2_btn     out  P2 buttons, same ordering
//   btn_valid  out  one-cycle pulse when p1_btn/p2_btn update
//
// Build option
//   PAD_READER_DEBOUNCE_EN : when defined, a player's output only takes a new
//   value once two consecutive polls captured the same bits.
// -----------------------------------------------------------------------------
module pad_reader #(
  parameter int unsigned PAD_CLK_DIV   = 6,
  parameter logic [15:0] POLL_INTERVAL = 16'd40000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic [1:0]  pad_data,
  output logic [11:0] p1_btn,
  output logic [11:0] p2_btn,
  output logic        btn_valid
);

  typedef enum logic [2:0] {
    ST_WAIT     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [15:0] POLL_LAST  = POLL_INTERVAL - 16'd1;
  localparam logic [8:0]  DIV_LAST   = 9'(PAD_CLK_DIV - 1);
  localparam logic [8:0]  LATCH_LAST = 9'(2 * PAD_CLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST   = 4'd11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_poll_cnt;
  logic [8:0]  r_div_cnt;
  logic [3:0]  r_bit_idx;
  logic [11:0] r_shadow1;
  logic [11:0] r_shadow2;
  logic [11:0] r_p1_btn;
  logic [11:0] r_p2_btn;
  logic        r_btn_valid;
  logic        r_pad_latch;
  logic        r_pad_clk;

  logic        w_poll_wrap;
  logic        w_div_last;
  logic        w_latch_nxt;
  logic        w_clk_nxt;

  assign w_poll_wrap = (r_poll_cnt == POLL_LAST);
  assign w_div_last  = (r_div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and next values of the pad strobes. The strobes are
  // computed from the next state so the registered pins line up exactly with
  // the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_latch_nxt = 1'b0;
    w_clk_nxt   = 1'b1;
    case (r_state)
      ST_WAIT:     if (w_poll_wrap) w_state_nxt = ST_LATCH;
      ST_LATCH:    if (r_div_cnt == LATCH_LAST) w_state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_div_last) w_state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (w_div_last) begin
          w_state_nxt = (r_bit_idx == BIT_LAST) ? ST_DONE : ST_SHIFT_LO;
        end
      end
      ST_DONE:     w_state_nxt = ST_WAIT;
      default:     w_state_nxt = ST_WAIT;
    endcase
    w_latch_nxt = (w_state_nxt == ST_LATCH);
    w_clk_nxt   = (w_state_nxt != ST_SHIFT_LO);
  end

  // ---------------------------------------------------------------------------
  // Timing counters. The poll counter free-runs across the whole poll so the
  // period is exactly POLL_INTERVAL; wrapping coincides with LATCH entry.
  // The divider restarts on every state entry and is parked in WAIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= 16'd0;
      r_div_cnt  <= 9'd0;
      r_bit_idx  <= 4'd0;
    end else begin
      r_poll_cnt <= w_poll_wrap ? 16'd0 : r_poll_cnt + 16'd1;

      if ((r_state == ST_WAIT) || (w_state_nxt != r_state)) begin
        r_div_cnt <= 9'd0;
      end else begin
        r_div_cnt <= r_div_cnt + 9'd1;
      end

      if (r_state == ST_LATCH) begin
        r_bit_idx <= 4'd0;
      end else if ((r_state == ST_SHIFT_HI) && w_div_last && (r_bit_idx != BIT_LAST)) begin
        r_bit_idx <= r_bit_idx + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pad pins, registered for glitch-free outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b1;
    end else begin
      r_pad_latch <= w_latch_nxt;
      r_pad_clk   <= w_clk_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture: sample in the last low cycle of pad_clk, just before the rising
  // edge that makes the pad advance. Wire data is inverted to active-high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow1 <= 12'd0;
      r_shadow2 <= 12'd0;
    end else if ((r_state == ST_SHIFT_LO) && w_div_last) begin
      r_shadow1[r_bit_idx] <= ~pad_data[0];
      r_shadow2[r_bit_idx] <= ~pad_data[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Publish: outputs only move at the end of DONE, so partial shifts are
  // never visible.
  // ---------------------------------------------------------------------------
`ifdef PAD_READER_DEBOUNCE_EN
  logic [11:0] r_prev1;
  logic [11:0] r_prev2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_btn    <= 12'd0;
      r_p2_btn    <= 12'd0;
      r_prev1     <= 12'd0;
      r_prev2     <= 12'd0;
      r_btn_valid <= 1'b0;
    end else begin
      r_btn_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        // A value is accepted only when it matches the previous poll.
        if (r_shadow1 == r_prev1) r_p1_btn <= r_shadow1;
        if (r_shadow2 == r_prev2) r_p2_btn <= r_shadow2;
        r_prev1 <= r_shadow1;
        r_prev2 <= r_shadow2;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_btn    <= 12'd0;
      r_p2_btn    <= 12'd0;
      r_btn_valid <= 1'b0;
    end else begin
      r_btn_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_p1_btn <= r_shadow1;
        r_p2_btn <= r_shadow2;
      end
    end
  end
`endif

  assign pad_latch = r_pad_latch;
  assign pad_clk   = r_pad_clk;
  assign p1_btn    = r_p1_btn;
  assign p2_btn    = r_p2_btn;
  assign btn_valid = r_btn_valid;

endmodule

// File: tb/tb_pad_reader.sv
// -----------------------------------------------------------------------------
// tb_pad_reader
//   Bench for pad_reader with PAD_CLK_DIV=2, POLL_INTERVAL=100. A mock pad
//   pair drives pad_data from a per-poll table of button values. A timing
//   model derived from cycle count since reset release predicts every output
//   each cycle; directed literal checks pin key moments.
// -----------------------------------------------------------------------------
module tb_pad_reader;

  localparam int D = 2;
  localparam int P = 100;
`ifdef PAD_READER_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        pad_latch;
  logic        pad_clk;
  logic [1:0]  pad_data;
  logic [11:0] p1_btn;
  logic [11:0] p2_btn;
  logic        btn_valid;

  pad_reader #(
    .PAD_CLK_DIV   (D),
    .POLL_INTERVAL (16'd100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .p1_btn    (p1_btn),
    .p2_btn    (p2_btn),
    .btn_valid (btn_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit running = 1'b0;
  int last_valid_t = -1;

  // Button values (active-high) the pads present on successive polls.
  logic [11:0] pv1 [4];
  logic [11:0] pv2 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  // ---------------- mock gamepads ----------------
  logic [11:0] sr1 = 12'hFFF;
  logic [11:0] sr2 = 12'hFFF;
  logic lat_prev = 1'b0;
  logic pclk_prev = 1'b1;
  int lcount = 0;

  assign pad_data = {sr2[0], sr1[0]};

  always @(negedge clk) begin
    if (pad_latch && !lat_prev) begin
      sr1 = ~pv1[(lcount < 4) ? lcount : 3];
      sr2 = ~pv2[(lcount < 4) ? lcount : 3];
      lcount++;
    end else if (!pad_latch && pad_clk && !pclk_prev) begin
      sr1 = {1'b1, sr1[11:1]};
      sr2 = {1'b1, sr2[11:1]};
    end
    lat_prev  = pad_latch;
    pclk_prev = pad_clk;
  end

  // ---------------- behavioural model ----------------
  function automatic logic exp_latch(input int tt);
    return (tt >= P) && ((tt % P) < 2 * D);
  endfunction

  function automatic logic exp_clk(input int tt);
    int p;
    int k;
    if (tt < P) return 1'b1;
    p = tt % P;
    if (p < 2 * D || p >= 26 * D) return 1'b1;
    k = p - 2 * D;
    return ((k / D) % 2) == 1;
  endfunction

  function automatic logic exp_valid(input int tt);
    return (tt >= P) && ((tt % P) == 26 * D + 1);
  endfunction

  function automatic int npolls(input int tt);
    if (tt < P + 26 * D + 1) return 0;
    return (tt - (P + 26 * D + 1)) / P + 1;
  endfunction

  function automatic logic [11:0] exp_btn(input int pl, input int n);
    logic [11:0] val;
    logic [11:0] prev;
    logic [11:0] cur;
    val = 12'h000;
    prev = 12'h000;
    for (int j = 0; j < n; j++) begin
      cur = (pl == 1) ? pv1[(j < 4) ? j : 3] : pv2[(j < 4) ? j : 3];
      if (!DEB || cur == prev) val = cur;
      prev = cur;
    end
    return val;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (running) begin
      t++;
      chk("pad_latch", 32'(pad_latch), 32'(exp_latch(t)));
      chk("pad_clk", 32'(pad_clk), 32'(exp_clk(t)));
      chk("btn_valid", 32'(btn_valid), 32'(exp_valid(t)));
      chk("p1_btn", 32'(p1_btn), 32'(exp_btn(1, npolls(t))));
      chk("p2_btn", 32'(p2_btn), 32'(exp_btn(2, npolls(t))));
      if (btn_valid) begin
        if (last_valid_t >= 0) chk("valid_spacing", 32'(t - last_valid_t), 32'(P));
        last_valid_t = t;
      end
    end
  end

  task automatic run_until(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (t >= target) break;
      @(negedge clk);
    end
    chk("reach_cycle", 32'(t), 32'(target));
  endtask

  task automatic do_release();
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    last_valid_t = -1;
    running = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    running = 1'b0;
    reset_n = 1'b0;
    #1;
    lcount = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    pv1 = '{12'h001, 12'h003, 12'h003, 12'h003};
    pv2 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_clk", 32'(pad_clk), 32'd1);
    chk("rst_p1", 32'(p1_btn), 32'd0);
    chk("rst_p2", 32'(p2_btn), 32'd0);
    chk("rst_valid", 32'(btn_valid), 32'd0);

    // Phase 1: timing landmarks and debounce sequence 001,003,003
    do_release();
    run_until(99);
    chk("latch_before", 32'(pad_latch), 32'd0);
    run_until(100);
    chk("latch_rise", 32'(pad_latch), 32'd1);
    chk("clk_in_latch", 32'(pad_clk), 32'd1);
    run_until(103);
    chk("latch_last", 32'(pad_latch), 32'd1);
    run_until(104);
    chk("latch_fall", 32'(pad_latch), 32'd0);
    chk("clk_first_low", 32'(pad_clk), 32'd0);
    run_until(152);
    chk("no_valid_152", 32'(btn_valid), 32'd0);
    run_until(153);
    chk("valid_153", 32'(btn_valid), 32'd1);
    chk("p1_poll1", 32'(p1_btn), DEB ? 32'h000 : 32'h001);
    chk("p2_poll1", 32'(p2_btn), DEB ? 32'h000 : 32'hFFF);
    run_until(253);
    chk("valid_253", 32'(btn_valid), 32'd1);
    chk("p1_poll2", 32'(p1_btn), DEB ? 32'h000 : 32'h003);
    chk("p2_poll2", 32'(p2_btn), 32'hFFF);
    run_until(353);
    chk("valid_353", 32'(btn_valid), 32'd1);
    chk("p1_poll3", 32'(p1_btn), 32'h003);

    // Phase 2: wire pattern A5C on P1, P2 wire tied low
    do_reset();
    pv1 = '{12'h5A3, 12'h5A3, 12'h5A3, 12'h5A3};
    pv2 = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    repeat (2) @(negedge clk);
    do_release();
    run_until(153);
    chk("p1_a5c_poll1", 32'(p1_btn), DEB ? 32'h000 : 32'h5A3);
    run_until(253);
    chk("p1_a5c", 32'(p1_btn), 32'h5A3);
    chk("p2_tied", 32'(p2_btn), 32'hFFF);

    // Phase 3: reset during bit-5 SHIFT_LO aborts the poll
    run_until(324);
    chk("bit5_low", 32'(pad_clk), 32'd0);
    do_reset();
    chk("abort_clk", 32'(pad_clk), 32'd1);
    chk("abort_latch", 32'(pad_latch), 32'd0);
    chk("abort_p1", 32'(p1_btn), 32'd0);
    chk("abort_p2", 32'(p2_btn), 32'd0);
    chk("abort_valid", 32'(btn_valid), 32'd0);
    pv1 = '{12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0};
    pv2 = '{12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F};
    repeat (2) @(negedge clk);
    do_release();
    run_until(152);
    chk("post_abort_no_valid", 32'(btn_valid), 32'd0);
    run_until(153);
    chk("post_abort_valid", 32'(btn_valid), 32'd1);
    run_until(253);
    chk("post_abort_p1", 32'(p1_btn), 32'h0F0);
    chk("post_abort_p2", 32'(p2_btn), 32'hF0F);

    @(negedge clk);
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
